// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encodings, framing constants and byte select helper
// Purpose : constants shared by the FIFO-draining UART transmitter.
// Contents: state encodings (IDLE, POP, LOAD, START, DATA, STOP),
//           BYTES_PER_WORD, BITS_PER_BYTE, sel_byte() helper.
package uart_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam int BYTES_PER_WORD = 3;
  localparam int BITS_PER_BYTE  = 8;

  // Byte 0 is the most significant byte of the word; it goes out first.
  function automatic logic [7:0] sel_byte(input logic [23:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[23:16];
      2'd1:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/baud_counter.sv
// rtl/baud_counter.sv - bit-period counter producing a tick on the last cycle of each bit
// Purpose : counts 0..CLKS_PER_BIT-1 while enabled.
// Ports   : clk, n_reset (async active-low), clear (reload to 0), en (count),
//           tick (high on the final cycle of a bit period while en).
module baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops 24-bit FIFO words and sends each as three 8N1 bytes, MSB byte first
// Purpose : sole consumer of the upstream FIFO; serialises every popped word.
// Ports   : clk, n_reset (async active-low)
//           fifo_data[DATA_W] / fifo_empty  - FIFO read side inputs
//           fifo_rd_en                      - one-cycle pop strobe
//           tx                              - UART line, idle high
//           busy                            - high from pop until last stop bit ends
//           word_done                       - one-cycle pulse as the FSM re-enters IDLE
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 24
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              word_done
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [DATA_W-1:0] r_word;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic [1:0]        r_byte_idx;
  logic [1:0]        w_byte_idx_next;
  logic              w_done_next;
  logic              w_tx_next;
  logic [7:0]        w_byte_next;
  logic              w_tick;
  logic              w_baud_en;
  logic              w_baud_clear;
  logic              r_tx;
  logic              r_busy;
  logic              r_rd_en;
  logic              r_word_done;

  // The counter only runs while a bit is on the line; any bit boundary or
  // non-line state reloads it so every bit gets a full period.
  assign w_baud_en    = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_baud_clear = w_tick || !w_baud_en;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .n_reset(n_reset),
    .clear  (w_baud_clear),
    .en     (w_baud_en),
    .tick   (w_tick)
  );

  always_comb begin
    w_state_next    = r_state;
    w_bit_idx_next  = r_bit_idx;
    w_byte_idx_next = r_byte_idx;
    w_done_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // fifo_empty is only consulted here, so a refill mid-word waits for IDLE.
        if (!fifo_empty) begin
          w_state_next = S_POP;
        end
      end
      S_POP: begin
        w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_state_next    = S_START;
        w_bit_idx_next  = 3'd0;
        w_byte_idx_next = 2'd0;
      end
      S_START: begin
        if (w_tick) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = 3'd0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'(BITS_PER_BYTE - 1)) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_byte_idx < 2'(BYTES_PER_WORD - 1)) begin
            w_byte_idx_next = r_byte_idx + 2'd1;
            w_state_next    = S_START;
          end else begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // tx is computed from the next state so the line register changes on the
  // same edge as the FSM, keeping the output glitch-free and cycle-aligned.
  assign w_byte_next = sel_byte(r_word, w_byte_idx_next);

  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_byte_next[w_bit_idx_next];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_idx   <= w_bit_idx_next;
      r_byte_idx  <= w_byte_idx_next;
      r_tx        <= w_tx_next;
      r_busy      <= (w_state_next != S_IDLE);
      r_rd_en     <= (w_state_next == S_POP);
      r_word_done <= w_done_next;
      // FIFO data is valid the cycle after the pop strobe, i.e. in LOAD.
      if (r_state == S_LOAD) begin
        r_word <= fifo_data;
      end
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_rd_en = r_rd_en;
  assign word_done  = r_word_done;

endmodule
